sudoku_solve_scheduler: RTL

Job scheduler sitting between the host-side control logic and two `sudoku_puzzle` engines. Allocates a free engine per job, round-robin when both are free. Holds the engine's start request until the engine acknowledges with busy. Enforces a per-job cycle timeout by aborting the engine. Queues tagged completion records in a 4-entry result FIFO with an interrupt.

---
 rtl/sudoku_solve_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sudoku_solve_scheduler.sv
// Job scheduler for two sudoku_puzzle engines: engine allocation, start/busy handshake,
// per-job timeout abort, and a 4-entry first-word-fall-through result FIFO with interrupt.
module sudoku_solve_scheduler #(
  parameter int TAG_W = 4,
  parameter int TMO_W = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               alloc_valid,
  input  logic [TAG_W-1:0]   alloc_tag,
  output logic               alloc_ready,
  output logic               alloc_engine,
  input  logic               launch_valid,
  input  logic               launch_engine,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic [1:0]         eng_busy,
  input  logic [1:0]         eng_solved,
  input  logic [1:0]         eng_stuck,
  input  logic [1:0]         eng_illegal,
  output logic [1:0]         start_solve,
  output logic [1:0]         abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TAG_W+4:0]   res_data,
  input  logic               irq_en,
  output logic               irq,
  output logic [5:0]         eng_state
);

  localparam int REC_W = TAG_W + 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESERVED = 3'd1,
    ST_STARTING = 3'd2,
    ST_RUNNING  = 3'd3,
    ST_ABORTING = 3'd4,
    ST_DONE     = 3'd5
  } eng_st_e;

  eng_st_e          state_q [2];
  eng_st_e          state_d [2];
  logic [TAG_W-1:0] tag_q   [2];
  logic [TAG_W-1:0] tag_d   [2];
  logic [TMO_W-1:0] cnt_q   [2];
  logic [TMO_W-1:0] cnt_d   [2];
  logic [3:0]       flags_q [2];   // {timeout, illegal, stuck, solved}
  logic [3:0]       flags_d [2];
  logic             last_grant_q, last_grant_d;

  logic [REC_W-1:0] fifo_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q;

  logic             idle0_s, idle1_s, alloc_fire_s;
  logic             fifo_full_s, fifo_empty_s, push_s, pop_s, push_eng_s;
  logic [REC_W-1:0] push_rec_s;

  // Allocation grant: alternate when both engines are free.
  always_comb begin
    idle0_s = (state_q[0] == ST_IDLE);
    idle1_s = (state_q[1] == ST_IDLE);
    alloc_ready = (idle0_s | idle1_s) & ~wb_rst_i;
    if (idle0_s && idle1_s) begin
      alloc_engine = ~last_grant_q;
    end else if (idle1_s) begin
      alloc_engine = 1'b1;
    end else begin
      alloc_engine = 1'b0;
    end
    alloc_fire_s = alloc_valid & alloc_ready;
    last_grant_d = alloc_fire_s ? alloc_engine : last_grant_q;
  end

  // Completion push arbitration: engine 0 wins a tie, one push per cycle.
  always_comb begin
    fifo_full_s  = (count_q == 3'd4);
    fifo_empty_s = (count_q == 3'd0);
    pop_s        = res_ready & ~fifo_empty_s;
    push_s       = 1'b0;
    push_eng_s   = 1'b0;
    if (!fifo_full_s) begin
      if (state_q[0] == ST_DONE) begin
        push_s     = 1'b1;
        push_eng_s = 1'b0;
      end else if (state_q[1] == ST_DONE) begin
        push_s     = 1'b1;
        push_eng_s = 1'b1;
      end else begin
        push_s     = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
    push_rec_s = {flags_q[push_eng_s], push_eng_s, tag_q[push_eng_s]};
  end

  // Per-engine job FSM next state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tag_d[i]   = tag_q[i];
      cnt_d[i]   = cnt_q[i];
      flags_d[i] = flags_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (alloc_fire_s && (alloc_engine == 1'(i))) begin
            state_d[i] = ST_RESERVED;
            tag_d[i]   = alloc_tag;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_RESERVED: begin
          if (launch_valid && (launch_engine == 1'(i))) begin
            state_d[i] = ST_STARTING;
            cnt_d[i]   = {TMO_W{1'b0}};
            flags_d[i] = 4'b0000;
          end else begin
            state_d[i] = ST_RESERVED;
          end
        end
        ST_STARTING, ST_RUNNING: begin
          if (cnt_q[i] != {TMO_W{1'b1}}) begin
            cnt_d[i] = cnt_q[i] + {{(TMO_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d[i] = cnt_q[i];
          end
          // Timeout wins over a same-cycle busy transition.
          if ((cfg_timeout != {TMO_W{1'b0}}) && (cnt_q[i] == cfg_timeout)) begin
            state_d[i]    = ST_ABORTING;
            flags_d[i][3] = 1'b1;
          end else if ((state_q[i] == ST_STARTING) && eng_busy[i]) begin
            state_d[i] = ST_RUNNING;
          end else if ((state_q[i] == ST_RUNNING) && !eng_busy[i]) begin
            state_d[i] = ST_DONE;
            flags_d[i] = {1'b0, eng_illegal[i], eng_stuck[i], eng_solved[i]};
          end else begin
            state_d[i] = state_q[i];
          end
        end
        ST_ABORTING: begin
          if (!eng_busy[i]) begin
            state_d[i] = ST_DONE;
            flags_d[i] = {1'b1, eng_illegal[i], eng_stuck[i], eng_solved[i]};
          end else begin
            state_d[i] = ST_ABORTING;
          end
        end
        ST_DONE: begin
          if (push_s && (push_eng_s == 1'(i))) begin
            state_d[i] = ST_IDLE;
          end else begin
            state_d[i] = ST_DONE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Engine FSM and job context registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        tag_q[i]   <= {TAG_W{1'b0}};
        cnt_q[i]   <= {TMO_W{1'b0}};
        flags_q[i] <= 4'b0000;
      end
      last_grant_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        tag_q[i]   <= tag_d[i];
        cnt_q[i]   <= cnt_d[i];
        flags_q[i] <= flags_d[i];
      end
      last_grant_q <= last_grant_d;
    end
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= {REC_W{1'b0}};
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= push_rec_s;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_q + 3'(push_s) - 3'(pop_s);
    end
  end

  // Output decode from registered state.
  always_comb begin
    start_solve = {state_q[1] == ST_STARTING, state_q[0] == ST_STARTING};
    abort       = {state_q[1] == ST_ABORTING, state_q[0] == ST_ABORTING};
    res_valid   = ~fifo_empty_s;
    if (fifo_empty_s) begin
      res_data = {REC_W{1'b0}};
    end else begin
      res_data = fifo_q[rd_ptr_q];
    end
    irq       = res_valid & irq_en;
    eng_state = {state_q[1], state_q[0]};
  end

endmodule
